// File: rtl/anfsqrt_pkg.sv
// Shared widths and the chaining record for the binary-search square-root stage.
package anfsqrt_pkg;

    localparam int WIDTH    = 32;
    localparam int WIDTH_C  = WIDTH + 1;
    localparam int WIDTH_SQ = 2 * WIDTH + 2;

    // One iteration's state, as handed from one stage to the next.
    typedef struct packed {
        logic [WIDTH-1:0] att;
        logic [WIDTH-1:0] eps;
        logic [WIDTH-1:0] res;
    } sqrt_triple_t;

endpackage

// File: rtl/anfsqrt_sqrtiu_if.sv
// Input/output triple bundle of one sqrt iteration stage; slave is the stage side.
interface anfsqrt_sqrtiu_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic [WIDTH-1:0] prev_att;
    logic [WIDTH-1:0] prev_eps;
    logic [WIDTH-1:0] prev_res;
    logic             out_valid;
    logic [WIDTH-1:0] this_att;
    logic [WIDTH-1:0] this_eps;
    logic [WIDTH-1:0] this_res;

    modport slave (
        input  in_valid, prev_att, prev_eps, prev_res,
        output out_valid, this_att, this_eps, this_res
    );

    modport master (
        output in_valid, prev_att, prev_eps, prev_res,
        input  out_valid, this_att, this_eps, this_res
    );

endinterface

// File: rtl/anfsqrt_sq_le.sv
// Combinational trial: cand = res + eps, accept when eps != 0 and cand^2 <= att.
module anfsqrt_sq_le
    import anfsqrt_pkg::*;
#(
    parameter int W = anfsqrt_pkg::WIDTH
) (
    input  logic [W-1:0] att_i,
    input  logic [W-1:0] eps_i,
    input  logic [W-1:0] res_i,
    output logic [W:0]   cand_o,
    output logic         accept_o
);

    logic [W:0]     cand_s;
    logic [2*W+1:0] cand_ext_s;
    logic [2*W+1:0] sq_s;
    logic [2*W+1:0] att_ext_s;

    // The carry bit is kept so an overflowing candidate squares past any radicand.
    always_comb begin
        cand_s     = {1'b0, res_i} + {1'b0, eps_i};
        cand_ext_s = {{(W+1){1'b0}}, cand_s};
        sq_s       = cand_ext_s * cand_ext_s;
        att_ext_s  = {{(W+2){1'b0}}, att_i};
        accept_o   = (eps_i != {W{1'b0}}) && (sq_s <= att_ext_s);
        cand_o     = cand_s;
    end

endmodule

// File: rtl/anfsqrt_sqrtiu.sv
// One registered iteration of a bit-serial integer square root; chainable or self-fed.
module anfsqrt_sqrtiu
    import anfsqrt_pkg::*;
#(
    parameter int WIDTH = anfsqrt_pkg::WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    anfsqrt_sqrtiu_if.slave bus
);

    logic [WIDTH:0]   cand_s;
    logic             accept_s;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] att_q,   att_d;
    logic [WIDTH-1:0] eps_q,   eps_d;
    logic [WIDTH-1:0] res_q,   res_d;

    anfsqrt_sq_le #(
        .W (WIDTH)
    ) u_sq_le (
        .att_i    (bus.prev_att),
        .eps_i    (bus.prev_eps),
        .res_i    (bus.prev_res),
        .cand_o   (cand_s),
        .accept_o (accept_s)
    );

    // Next iteration on a valid input; otherwise hold the triple and drop valid.
    always_comb begin
        valid_d = 1'b0;
        att_d   = att_q;
        eps_d   = eps_q;
        res_d   = res_q;
        if (bus.in_valid) begin
            valid_d = 1'b1;
            att_d   = bus.prev_att;
            eps_d   = bus.prev_eps >> 1;
            if (accept_s) begin
                res_d = cand_s[WIDTH-1:0];
            end else begin
                res_d = bus.prev_res;
            end
        end else begin
            valid_d = 1'b0;
        end
    end

    // Output registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            att_q   <= {WIDTH{1'b0}};
            eps_q   <= {WIDTH{1'b0}};
            res_q   <= {WIDTH{1'b0}};
        end else begin
            valid_q <= valid_d;
            att_q   <= att_d;
            eps_q   <= eps_d;
            res_q   <= res_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.this_att  = att_q;
    assign bus.this_eps  = eps_q;
    assign bus.this_res  = res_q;

endmodule

// File: tb/tb_anfsqrt_sqrtiu.sv
// Scoreboard bench for the sqrt iteration stage: directed vectors and feedback loops.
module tb_anfsqrt_sqrtiu;
    import anfsqrt_pkg::*;

    logic clk;
    logic rst_n;

    anfsqrt_sqrtiu_if #(.WIDTH(32)) bus ();

    anfsqrt_sqrtiu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sqrt_triple_t sb_q[$];
    sqrt_triple_t last_exp;
    int n_cmp;
    int n_err;

    // Monitor: zeros in reset, pop on out_valid, otherwise outputs must hold.
    always @(negedge clk) begin
        sqrt_triple_t exp_t;
        if (!rst_n) begin
            n_cmp++;
            last_exp = '0;
            if (bus.out_valid !== 1'b0 || bus.this_att !== 32'd0 ||
                bus.this_eps !== 32'd0 || bus.this_res !== 32'd0) begin
                n_err++;
                $display("FAIL reset_state: got v=%0b att=%0h eps=%0h res=%0h, want all 0",
                         bus.out_valid, bus.this_att, bus.this_eps, bus.this_res);
            end
        end else if (bus.out_valid === 1'b1) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got att=%0h eps=%0h res=%0h, want no output",
                         bus.this_att, bus.this_eps, bus.this_res);
            end else begin
                exp_t = sb_q.pop_front();
                last_exp = exp_t;
                if (bus.this_att !== exp_t.att || bus.this_eps !== exp_t.eps ||
                    bus.this_res !== exp_t.res) begin
                    n_err++;
                    $display("FAIL iteration: got att=%0h eps=%0h res=%0h, want att=%0h eps=%0h res=%0h",
                             bus.this_att, bus.this_eps, bus.this_res,
                             exp_t.att, exp_t.eps, exp_t.res);
                end
            end
        end else begin
            n_cmp++;
            if (bus.this_att !== last_exp.att || bus.this_eps !== last_exp.eps ||
                bus.this_res !== last_exp.res) begin
                n_err++;
                $display("FAIL hold: got att=%0h eps=%0h res=%0h, want att=%0h eps=%0h res=%0h",
                         bus.this_att, bus.this_eps, bus.this_res,
                         last_exp.att, last_exp.eps, last_exp.res);
            end
        end
    end

    // Drive one valid triple for the next edge and record its expected result.
    task automatic issue(input logic [31:0] a, input logic [31:0] e, input logic [31:0] r,
                         input logic [31:0] xa, input logic [31:0] xe, input logic [31:0] xr);
        sqrt_triple_t t;
        bus.in_valid = 1'b1;
        bus.prev_att = a;
        bus.prev_eps = e;
        bus.prev_res = r;
        t.att = xa;
        t.eps = xe;
        t.res = xr;
        sb_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.prev_att = $urandom;
            bus.prev_eps = $urandom;
            bus.prev_res = $urandom;
            @(posedge clk);
            #1;
        end
    endtask

    // Self-fed 65536 loop: every accepted result is res=256, eps halves to 0.
    task automatic loop_65536(input int n);
        issue(32'd65536, 32'd256, 32'd0, 32'd65536, 32'd128, 32'd256);
        for (int i = 2; i <= n; i++) begin
            issue(bus.this_att, bus.this_eps, bus.this_res,
                  32'd65536, 32'd256 >> i, 32'd256);
        end
    endtask

    logic [31:0] exp100_res [5];
    logic [31:0] exp100_eps [5];

    initial begin
        logic [31:0] xr;
        n_cmp = 0;
        n_err = 0;
        last_exp = '0;
        bus.in_valid = 1'b0;
        bus.prev_att = 32'd0;
        bus.prev_eps = 32'd0;
        bus.prev_res = 32'd0;
        exp100_res = '{32'd8, 32'd8, 32'd10, 32'd10, 32'd10};
        exp100_eps = '{32'd4, 32'd2, 32'd1, 32'd0, 32'd0};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        loop_65536(64);
        idle(2);

        issue(32'd100, 32'd8, 32'd0, 32'd100, exp100_eps[0], exp100_res[0]);
        for (int i = 1; i < 5; i++) begin
            issue(bus.this_att, bus.this_eps, bus.this_res, 32'd100, exp100_eps[i], exp100_res[i]);
        end
        idle(2);

        issue(32'hFFFF_FFFF, 32'h8000, 32'd0, 32'hFFFF_FFFF, 32'h4000, 32'h8000);
        for (int i = 2; i <= 18; i++) begin
            xr = (i >= 16) ? 32'hFFFF : ((32'hFFFF << (16 - i)) & 32'hFFFF);
            issue(bus.this_att, bus.this_eps, bus.this_res, 32'hFFFF_FFFF, 32'h8000 >> i, xr);
        end
        idle(2);

        issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
        idle(1);
        issue(32'd50, 32'd0, 32'd3, 32'd50, 32'd0, 32'd3);
        idle(1);

        issue(32'd1234, 32'd16, 32'd0, 32'd1234, 32'd8, 32'd16);
        idle(3);

        loop_65536(4);
        #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        sb_q.delete();
        #1;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.this_att !== 32'd0 ||
            bus.this_eps !== 32'd0 || bus.this_res !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset: got v=%0b att=%0h eps=%0h res=%0h, want all 0",
                     bus.out_valid, bus.this_att, bus.this_eps, bus.this_res);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        loop_65536(10);
        idle(3);

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending results, want 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/anfsqrt_sqrtiu.md
Name: anfsqrt_sqrtiu

Overview:
- One iteration stage of a bit-serial binary-search integer square root.
- Each accepted input triple has these fields:
  - att: the radicand being attempted.
  - eps: the current step weight.
  - res: the partial root.
- Per accepted triple, the stage tries res+eps as the root, keeps it if (res+eps)^2 <= att, then halves eps.
- Outputs are registered. The stage is either chained N-deep as a pipeline or fed back on itself, in which case res converges to floor(sqrt(att)) once eps reaches 0.

Parameters:
- WIDTH, 32, bit width of att, eps and res.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  prev_* triple is valid this cycle.
- prev_att  input  WIDTH  radicand from the previous iteration.
- prev_eps  input  WIDTH  step weight from the previous iteration.
- prev_res  input  WIDTH  partial root from the previous iteration.
- out_valid  output  1  this_* triple holds a freshly computed iteration.
- this_att  output  WIDTH  radicand, passed through.
- this_eps  output  WIDTH  next step weight.
- this_res  output  WIDTH  updated partial root.

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: out_valid, this_att, this_eps and this_res all go to 0 immediately, with no clock needed. Asserting reset mid-run discards the in-flight iteration. The first accept after release behaves as a fresh start.
- Latency: 1 cycle. No backpressure; a valid input is accepted on every rising edge where in_valid=1.
- On a rising edge with in_valid=1:
  - cand = prev_res + prev_eps, computed at WIDTH+1 bits (carry kept).
  - sq = cand*cand, computed at 2*WIDTH+2 bits.
  - accept = (prev_eps != 0) && (sq <= zero-extended prev_att).
  - this_res <= accept ? cand[WIDTH-1:0] : prev_res.
  - this_eps <= prev_eps >> 1 (logical shift).
  - this_att <= prev_att.
  - out_valid <= 1.
- On a rising edge with in_valid=0: this_* registers hold their values; out_valid <= 0.
- eps = 0 is a fixed point: res is unchanged, eps stays 0, att passes through. The stage remains stable indefinitely when fed back on itself.
- Overflow: if cand >= 2^WIDTH, then sq > any att, so accept=0 and res is unchanged. No wrap-around of res is possible.
- The algorithm does not require eps to be a power of two. Callers wanting an exact floor-sqrt use eps = 2^k with 2^(k+1) > sqrt(att) and res = 0.
- The comparison is purely combinational before the register. No multi-cycle multiply.

Decomposition:
- Package anfsqrt_pkg:
  - localparam WIDTH default 32.
  - Helper widths WIDTH+1 and 2*WIDTH+2.
  - No typedefs beyond a packed struct {att, eps, res} for chaining stages.
- One natural sub-module, anfsqrt_sq_le: combinational cand = res+eps, squares it, and outputs accept (cand^2 <= att with eps != 0) plus cand. The top wraps it with the registers and valid logic.

Test Plan:
- Feedback loop (this_* -> prev_*, in_valid=1):
  - Stimulus: start att=65536, eps=256, res=0.
  - First cycle: res=256, eps=128.
  - After 9 iterations: eps=0, res=256. Res and eps then hold for the remaining 55 cycles, and att stays 65536 throughout.
- Feedback loop:
  - Stimulus: att=100, eps=8, res=0.
  - res sequence 8, 8, 10, 10, 10 with eps 4, 2, 1, 0, 0; final res=10.
- Max radicand:
  - Stimulus: att=0xFFFFFFFF, eps=0x8000, res=0, fed back.
  - Converges to res=65535 (0xFFFF), eps=0. 65536 is never accepted.
- Overflow guard, single step:
  - Stimulus: att=0xFFFFFFFF, eps=1, res=0xFFFFFFFF.
  - Response: this_res=0xFFFFFFFF, this_eps=0, out_valid=1.
- Valid/hold:
  - Stimulus: in_valid pulses 1 then 0 for 3 cycles with changing prev_* values.
  - Response: outputs update only on the valid edge; out_valid is 1 for exactly one cycle; this_* hold during in_valid=0.
- Async reset mid-run:
  - Stimulus: drop rst_n between clock edges during the 65536 feedback loop.
  - Response: all outputs are 0 immediately. After release, reloading att=65536, eps=256, res=0 gives res=256 nine iterations later.
